input_unit: RTL and testbench
=============================

INPUT_UNIT -- requirements
Module: input_unit

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the key stability window in Clock cycles (10 ms at 50 MHz); legal range 2..2^20.
REQ-002 SHALL have port Clock  in  1  processor clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port SW  in  16  board slide switches; asynchronous, not debounced.
REQ-005 SHALL have port KEY_N  in  1  enter push-button; active-low, asynchronous, bouncing.
REQ-006 SHALL have port getInput  in  1  control-unit request; held high while an IN instruction stalls.
REQ-007 SHALL have port Input_Data  out  32  captured switch value for the register-file write path.
REQ-008 SHALL have port Input_Ready  out  1  capture complete; releases the pipeline stall.
REQ-009 SHALL have port Waiting  out  1  high while awaiting a key press (drives a board LED).

Function
REQ-010 SHALL pass SW and KEY_N each through a 2-flop synchronizer; all downstream logic uses only synchronized values.
REQ-011 SHALL debounce the synchronized key: the counter clears whenever raw equals stable; the stable level takes the raw value once raw has differed from stable for DEBOUNCE_CYCLES consecutive cycles.
REQ-012 SHALL generate a one-cycle press pulse on a stable 1->0 transition of the debounced key; releases generate nothing.
REQ-013 SHALL implement FSM states IDLE, WAIT and DONE.
REQ-014 SHALL transition IDLE->WAIT on the cycle getInput=1 is sampled.
REQ-015 SHALL, in WAIT with a press pulse, load Input_Data from the synchronized SW and transition to DONE; Input_Ready=1 on the next cycle, coincident with the new Input_Data.
REQ-016 SHALL transition WAIT->IDLE without capture if getInput drops in WAIT; Input_Data is unchanged.
REQ-017 SHALL hold Input_Ready=1 throughout DONE and return to IDLE on the cycle getInput=0 is sampled (four-phase handshake).
REQ-018 SHALL ignore press pulses in IDLE and DONE; presses are not queued.
REQ-019 SHALL treat a key held down before WAIT is entered as not pressed; the user must release and press again.
REQ-020 SHALL ignore a press pulse that coincides with the IDLE->WAIT transition.
REQ-021 SHALL hold Input_Data between captures; Waiting = (state==WAIT).

Reset
REQ-022 SHALL, on Reset, set state to IDLE, Input_Data=0, Input_Ready=0, Waiting=0, debounce counter=0, debounced key=1 (released), and synchronizer flops to 1 for the key and 0 for SW.
REQ-023 SHALL abandon a transaction on Reset asserted in WAIT or DONE, with no capture.

Configuration
REQ-024 SHALL, with macro INPUT_SIGN_EXT_EN defined, set Input_Data[31:16] to SW[15] (sign-extended).
REQ-025 SHALL, without INPUT_SIGN_EXT_EN, set Input_Data[31:16]=0 (zero-extended).

Structure
REQ-026 SHALL take the FSM state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2) and the data-width constant 32 from shared package mips_io_pkg.
REQ-027 SHALL place the key synchronizer, debounce counter and edge detector in sub-module key_debounce, which has parameter DEBOUNCE_CYCLES and outputs the stable level and the press pulse.
REQ-028 SHALL contain no latches and no logic clocked by any signal other than Clock.

Verification (bench overrides DEBOUNCE_CYCLES=4)
REQ-029 SHALL cover basic capture: SW=16'h00A5, getInput=1, clean key press held 10 cycles -> Input_Ready=1 within sync+4+2 cycles, Input_Data=32'h000000A5; drop getInput -> Input_Ready=0 next cycle.
REQ-030 SHALL cover sign extension: SW=16'h8001 -> Input_Data=32'hFFFF8001 with INPUT_SIGN_EXT_EN, 32'h00008001 without.
REQ-031 SHALL cover bounce rejection: key toggled every 2 cycles for 20 cycles, then held low -> exactly one capture, no Input_Ready during the toggling.
REQ-032 SHALL cover held-key and idle presses: press in IDLE, or key held low before getInput rises -> Waiting=1, no Input_Ready; release, then press -> capture.
REQ-033 SHALL cover abort: getInput dropped in WAIT -> IDLE, Input_Data retains its prior value, no Input_Ready.
REQ-034 SHALL cover reset mid-operation: Reset pulsed in DONE -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/mips_io_pkg.sv
// -----------------------------------------------------------------------------
// mips_io_pkg
//
// Shared definitions for the board input path of the MIPS system:
//   - DATA_W      : register-file write width (32)
//   - SW_W        : slide-switch bank width (16)
//   - io_state_e  : input-unit FSM encoding (IDLE=0, WAIT=1, DONE=2)
//   - extend_sw() : widens a switch word to DATA_W, zero- or sign-extended
// -----------------------------------------------------------------------------
package mips_io_pkg;

  localparam int DATA_W = 32;
  localparam int SW_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } io_state_e;

  // The top bits replicate the switch MSB only when sign_en is set.
  // Otherwise they are zero.
  function automatic logic [DATA_W-1:0] extend_sw(input logic [SW_W-1:0] sw,
                                                  input logic            sign_en);
    extend_sw = {{(DATA_W - SW_W){sign_en & sw[SW_W-1]}}, sw};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//
// Conditions the bouncing, active-low enter key into a clean level and a
// one-cycle press pulse.
//
// Ports:
//   Clock        in   system clock; every register updates on its rising edge
//   Reset        in   synchronous, active-high reset
//   key_n_i      in   raw active-low key; asynchronous to Clock
//   key_level_o  out  debounced key level (1 = released)
//   key_press_o  out  one-cycle pulse on a debounced 1->0 (press) transition
//
// Parameter:
//   DEBOUNCE_CYCLES  number of consecutive cycles the synchronized key must
//                    disagree with the stable level before the stable level
//                    follows it. Legal range is 2..2^20.
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic key_n_i,
  output logic key_level_o,
  output logic key_press_o
);

  // The counter only needs to reach DEBOUNCE_CYCLES-1. At that count the
  // stable level flips, so DEBOUNCE_CYCLES >= 2 always gives CNT_W >= 1.
  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_meta_q, key_sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d;

  // Two-flop synchronizer. It resets to "released" so that no phantom press
  // appears when reset is released.
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples pre-edge values. This keeps the synchronizer a true two-stage chain.
    if (Reset) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
    end else begin
      key_meta_q <= key_n_i;
      key_sync_q <= key_meta_q;
    end
  end

  // Any sample that agrees with the stable level restarts the window.
  // A press pulse is raised only on the 1->0 flip of the stable level.
  always_comb begin
    // NOTE: every output of this block gets a default first. Paths that skip an
    // assignment then cannot infer a latch.
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (key_sync_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = key_sync_q;
      cnt_d    = '0;
      press_d  = ~key_sync_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  assign key_level_o = stable_q;
  assign key_press_o = press_q;

endmodule

// File: rtl/input_unit.sv
// -----------------------------------------------------------------------------
// input_unit
//
// Services the IN instruction. While the control unit holds getInput, the
// unit waits for a debounced press of the enter key. On that press it captures
// the slide switches into Input_Data and raises Input_Ready until getInput
// drops (four-phase handshake).
//
// Ports:
//   Clock        in   1   processor clock; all state updates on its rising edge
//   Reset        in   1   synchronous, active-high reset
//   SW           in   16  slide switches (asynchronous, not debounced)
//   KEY_N        in   1   enter push-button (active-low, bouncing)
//   getInput     in   1   request from control unit, held during the stall
//   Input_Data   out  32  captured switch word for the register-file write
//   Input_Ready  out  1   capture complete; releases the stall
//   Waiting      out  1   high while waiting for a key press (board LED)
//
// Parameter:
//   DEBOUNCE_CYCLES  key stability window in clock cycles (default 10 ms at 50 MHz)
//
// Build option:
//   INPUT_SIGN_EXT_EN  when defined, Input_Data[31:16] replicates SW[15].
//                      Otherwise the upper half is zero.
// -----------------------------------------------------------------------------
module input_unit
  import mips_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [SW_W-1:0]   SW,
  input  logic              KEY_N,
  input  logic              getInput,
  output logic [DATA_W-1:0] Input_Data,
  output logic              Input_Ready,
  output logic              Waiting
);

`ifdef INPUT_SIGN_EXT_EN
  localparam logic SIGN_EXT = 1'b1;
`else
  localparam logic SIGN_EXT = 1'b0;
`endif

  logic [SW_W-1:0]   sw_meta_q, sw_sync_q;
  logic              key_level, key_press;
  io_state_e         state_q;
  logic [DATA_W-1:0] data_q;
  logic              ready_q;
  logic              waiting_q;

  // Switch synchronizer. Each bit is synchronized on its own. The switches are
  // only captured after a human-scale key press, so switches that are still
  // settling are not a concern.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
    end
  end

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .Clock       (Clock),
    .Reset       (Reset),
    .key_n_i     (KEY_N),
    .key_level_o (key_level),
    .key_press_o (key_press)
  );

  // Handshake FSM. All outputs are registered and change with the state.
  // This makes Input_Ready rise in the same cycle that Input_Data takes the
  // captured value.
  //
  // Press pulses are acted on only in WAIT. This covers three cases:
  //   - A press in IDLE or DONE is dropped.
  //   - A press that coincides with IDLE->WAIT is dropped.
  //   - A key held down before WAIT produces no new pulse.
  // In each case the user must release the key and press it again.
  // A falling getInput in WAIT wins over a simultaneous press, so an
  // abandoned request never captures.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      data_q    <= '0;
      ready_q   <= 1'b0;
      waiting_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (getInput) begin
            state_q   <= WAIT;
            waiting_q <= 1'b1;
          end
        end
        WAIT: begin
          if (!getInput) begin
            state_q   <= IDLE;
            waiting_q <= 1'b0;
          end else if (key_press && !key_level) begin
            data_q    <= extend_sw(sw_sync_q, SIGN_EXT);
            ready_q   <= 1'b1;
            waiting_q <= 1'b0;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (!getInput) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          ready_q   <= 1'b0;
          waiting_q <= 1'b0;
        end
      endcase
    end
  end

  assign Input_Data  = data_q;
  assign Input_Ready = ready_q;
  assign Waiting     = waiting_q;

endmodule

// File: tb/tb_input_unit.sv
// -----------------------------------------------------------------------------
// tb_input_unit
//
// Directed scenarios plus a randomized tail for input_unit, using
// DEBOUNCE_CYCLES = 4.
//
// The reference model is transaction-level:
//   - The key seen by the debouncer is KEY_N from two edges earlier.
//   - The stable level flips once the last N seen samples all disagree with it.
//   - A press on a 1->0 flip is honoured on the following edge, but only while
//     a request is waiting.
// Outputs are compared after every rising edge.
// -----------------------------------------------------------------------------
module tb_input_unit;

  localparam int N = 4;

`ifdef INPUT_SIGN_EXT_EN
  localparam bit SEXT = 1'b1;
`else
  localparam bit SEXT = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] SW;
  logic        KEY_N;
  logic        getInput;
  logic [31:0] Input_Data;
  logic        Input_Ready;
  logic        Waiting;

  always #5 Clock = ~Clock;

  input_unit #(.DEBOUNCE_CYCLES(N)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .SW          (SW),
    .KEY_N       (KEY_N),
    .getInput    (getInput),
    .Input_Data  (Input_Data),
    .Input_Ready (Input_Ready),
    .Waiting     (Waiting)
  );

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_WAIT, M_DONE} m_state_e;

  m_state_e    m_state;
  logic [31:0] m_data;
  bit          m_stable;
  bit          m_press;
  bit          key_h[$];
  logic [15:0] sw_h[$];
  bit          seen[$];

  int    total = 0;
  int    bad   = 0;
  int    rises = 0;
  bit    prev_ready = 1'b0;
  string phase = "init";

  function automatic logic [31:0] expect_word(input logic [15:0] v);
    return SEXT ? 32'($signed(v)) : 32'(v);
  endfunction

  task automatic model_edge();
    bit          yk;
    bit          flip;
    bit          press_now;
    logic [15:0] swk;
    if (Reset) begin
      m_state  = M_IDLE;
      m_data   = '0;
      m_stable = 1'b1;
      m_press  = 1'b0;
      key_h    = '{1'b1, 1'b1};
      sw_h     = '{16'h0, 16'h0};
      seen.delete();
      return;
    end
    yk  = key_h[key_h.size()-2];
    swk = sw_h[sw_h.size()-2];
    key_h.push_back(KEY_N);
    sw_h.push_back(SW);
    void'(key_h.pop_front());
    void'(sw_h.pop_front());

    press_now = m_press;
    case (m_state)
      M_IDLE: if (getInput) m_state = M_WAIT;
      M_WAIT: begin
        if (!getInput) m_state = M_IDLE;
        else if (press_now) begin
          m_data  = expect_word(swk);
          m_state = M_DONE;
        end
      end
      default: if (!getInput) m_state = M_IDLE;
    endcase

    seen.push_back(yk);
    if (seen.size() > N) void'(seen.pop_front());
    flip = (seen.size() == N);
    foreach (seen[i]) if (seen[i] == m_stable) flip = 1'b0;
    m_press = 1'b0;
    if (flip) begin
      m_stable = ~m_stable;
      m_press  = (m_stable == 1'b0);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge Clock);
      model_edge();
      #1;
      chk("data",    Input_Data,            m_data);
      chk("ready",   {31'b0, Input_Ready},  {31'b0, m_state == M_DONE});
      chk("waiting", {31'b0, Waiting},      {31'b0, m_state == M_WAIT});
      if (Input_Ready === 1'b1 && !prev_ready) rises++;
      prev_ready = (Input_Ready === 1'b1);
      @(negedge Clock);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          r0;
    int          hold;
    logic [15:0] sw_b;
    logic [31:0] last_cap;

    key_h    = '{1'b1, 1'b1};
    sw_h     = '{16'h0, 16'h0};
    m_state  = M_IDLE;
    m_data   = '0;
    m_stable = 1'b1;
    m_press  = 1'b0;

    // Reset state.
    phase = "reset";
    Reset = 1'b1; KEY_N = 1'b1; getInput = 1'b0; SW = 16'($urandom);
    cyc(3);
    chk("rst_data", Input_Data, 32'h0);
    chk("rst_ready", {31'b0, Input_Ready}, 32'h0);
    chk("rst_waiting", {31'b0, Waiting}, 32'h0);
    Reset = 1'b0;
    cyc(3);

    // Basic capture.
    phase = "basic";
    SW = 16'h00A5;
    cyc(3);
    getInput = 1'b1;
    cyc(1);
    KEY_N = 1'b0;
    cyc(10);
    chk("basic_data", Input_Data, 32'h000000A5);
    chk("basic_ready", {31'b0, Input_Ready}, 32'h1);
    KEY_N = 1'b1; getInput = 1'b0;
    cyc(1);
    chk("basic_release", {31'b0, Input_Ready}, 32'h0);
    cyc(8);

    // Sign / zero extension.
    phase = "extend";
    SW = 16'h8001;
    cyc(3);
    getInput = 1'b1;
    cyc(1);
    KEY_N = 1'b0;
    cyc(10);
    chk("ext_data", Input_Data, SEXT ? 32'hFFFF8001 : 32'h00008001);
    KEY_N = 1'b1; getInput = 1'b0;
    cyc(9);

    // Bounce rejection.
    phase = "bounce";
    sw_b = 16'($urandom);
    SW = sw_b;
    r0 = rises;
    getInput = 1'b1;
    cyc(1);
    for (int i = 0; i < 10; i++) begin
      KEY_N = i[0];
      cyc(2);
    end
    chk("bounce_quiet", 32'(rises - r0), 32'd0);
    KEY_N = 1'b0;
    cyc(10);
    chk("bounce_one", 32'(rises - r0), 32'd1);
    chk("bounce_data", Input_Data, expect_word(sw_b));
    KEY_N = 1'b1; getInput = 1'b0;
    cyc(9);

    // Press in IDLE is ignored.
    phase = "idle_press";
    r0 = rises;
    KEY_N = 1'b0;
    cyc(10);
    KEY_N = 1'b1;
    cyc(8);
    chk("idle_no_ready", 32'(rises - r0), 32'd0);

    // A key held before the request is not a press.
    phase = "held";
    sw_b = 16'($urandom);
    SW = sw_b;
    KEY_N = 1'b0;
    cyc(8);
    getInput = 1'b1;
    cyc(8);
    chk("held_waiting", {31'b0, Waiting}, 32'h1);
    chk("held_no_ready", 32'(rises - r0), 32'd0);
    KEY_N = 1'b1;
    cyc(8);
    KEY_N = 1'b0;
    cyc(10);
    chk("held_capture", {31'b0, Input_Ready}, 32'h1);
    chk("held_data", Input_Data, expect_word(sw_b));
    last_cap = expect_word(sw_b);
    KEY_N = 1'b1; getInput = 1'b0;
    cyc(9);

    // Press pulse coincident with IDLE->WAIT is ignored.
    phase = "coincide";
    r0 = rises;
    KEY_N = 1'b0;
    cyc(6);
    getInput = 1'b1;
    cyc(7);
    chk("coin_waiting", {31'b0, Waiting}, 32'h1);
    chk("coin_no_ready", 32'(rises - r0), 32'd0);
    KEY_N = 1'b1;
    cyc(8);
    getInput = 1'b0;
    cyc(2);

    // Abort in WAIT.
    phase = "abort";
    SW = 16'($urandom);
    getInput = 1'b1;
    cyc(3);
    getInput = 1'b0;
    cyc(1);
    chk("abort_data", Input_Data, last_cap);
    chk("abort_ready", {31'b0, Input_Ready}, 32'h0);
    chk("abort_waiting", {31'b0, Waiting}, 32'h0);

    // Reset while in DONE.
    phase = "reset_done";
    getInput = 1'b1;
    cyc(1);
    KEY_N = 1'b0;
    cyc(10);
    chk("rd_ready_before", {31'b0, Input_Ready}, 32'h1);
    KEY_N = 1'b1;
    Reset = 1'b1;
    cyc(1);
    chk("rd_data", Input_Data, 32'h0);
    chk("rd_ready", {31'b0, Input_Ready}, 32'h0);
    chk("rd_waiting", {31'b0, Waiting}, 32'h0);
    Reset = 1'b0; getInput = 1'b0;
    cyc(8);

    // Randomized tail, checked against the model every cycle.
    phase = "random";
    hold = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 11) == 0) getInput = ~getInput;
      if ($urandom_range(0, 19) == 0) SW = 16'($urandom);
      hold--;
      if (hold == 0) begin
        KEY_N = ~KEY_N;
        hold  = $urandom_range(1, 9);
      end
      cyc(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
